// File: rtl/rv_muldiv_iterative.sv
// Iterative RISC-V M-extension multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro RV_MULDIV_EARLY_OUT_EN finishes divide-by-zero, signed overflow and zero-operand multiplies early.
module rv_muldiv_iterative #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            en,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIN
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     opb_q, opb_d;
    logic                neg_q, neg_d;
    logic                force_q, force_d;
    logic [XLEN-1:0]     force_val_q, force_val_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    op_e                 op_in;
    logic                a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic                b_zero, div_ovf, mul_zero;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   mul_full;
    logic [XLEN-1:0]     div_mag, div_val, fin_val;

    assign op_in = op_e'(op);

    // Operand conditioning at the start edge: magnitudes plus the sign to restore in FIN.
    always_comb begin
        a_sgn    = (op_in == OP_MULH) || (op_in == OP_MULHSU) || (op_in == OP_DIV) || (op_in == OP_REM);
        b_sgn    = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
        a_neg    = a_sgn && a[XLEN-1];
        b_neg    = b_sgn && b[XLEN-1];
        a_abs    = a_neg ? -a : a;
        b_abs    = b_neg ? -b : b;
        b_zero   = (b == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM))
                   && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        mul_zero = !op[2] && ((a == '0) || b_zero);
    end

    // One iteration of each algorithm; acc holds product, or remainder:quotient.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
        div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Sign fix-up and output selection for the FIN cycle.
    always_comb begin
        mul_full = neg_q ? -acc_q : acc_q;
        div_mag  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        div_val  = neg_q ? -div_mag : div_mag;
        if (force_q)
            fin_val = force_val_q;
        else if (op_q[2])
            fin_val = div_val;
        else if (op_q[1:0] == 2'b00)
            fin_val = mul_full[XLEN-1:0];
        else
            fin_val = mul_full[2*XLEN-1:XLEN];
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no path leaves a variable unassigned and no latch is inferred.
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        force_d     = force_q;
        force_val_d = force_val_q;
        done_d      = done_q;
        result_d    = result_q;

        if (en) begin
            done_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_d        = op_in;
                        cnt_d       = CW'(XLEN - 1);
                        neg_d       = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                        acc_d       = op[2] ? {{XLEN{1'b0}}, a_abs} : {{XLEN{1'b0}}, b_abs};
                        opb_d       = op[2] ? b_abs : a_abs;
                        force_d     = op[2] && (b_zero || div_ovf);
                        force_val_d = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);
                        state_d     = ST_CALC;
`ifdef RV_MULDIV_EARLY_OUT_EN
                        if (mul_zero) begin
                            force_d     = 1'b1;
                            force_val_d = '0;
                        end
                        if (force_d)
                            state_d = ST_FIN;
`endif
                    end
                end
                ST_CALC: begin
                    acc_d = op_q[2] ? div_next : mul_next;
                    if (cnt_q == '0)
                        state_d = ST_FIN;
                    else
                        cnt_d = cnt_q - 1'b1;
                end
                ST_FIN: begin
                    result_d = fin_val;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

`ifndef RV_MULDIV_EARLY_OUT_EN
    // Zero-operand multiplies run the full iteration; the flag is only consumed by the early-out path.
    logic unused_mul_zero;
    assign unused_mul_zero = mul_zero;
`endif

    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too; with a synchronous reset this costs little and keeps simulation free of X.
        if (srst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            force_q     <= 1'b0;
            force_val_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of every other flop.
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            force_q     <= force_d;
            force_val_q <= force_val_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
